mul_scheduler: RTL and testbench
================================

MUL_SCHEDULER -- requirements
Module: mul_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, operand FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 15, max WAIT cycles before the error flag is set.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  operand pair offered; in_ready  out  1  FIFO can accept.
REQ-007 in_a, in_b  in  32 each  multiplier, multiplicand, unsigned.
REQ-008 mul_valid_in  out  1  one-cycle start pulse to the downstream iterative multiplier.
REQ-009 mul_a, mul_b  out  32 each  operands, stable from the start pulse until the result is captured.
REQ-010 mul_valid_out  in  1  multiplier done level; mul_r  in  64  product.
REQ-011 out_valid  out  1, out_ready  in  1, out_r  out  64  result handshake.
REQ-012 jobs_done  out  16  count of results accepted at the output; err_timeout  out  1  sticky.

Function
REQ-013 In-handshake: a pair is written when in_valid && in_ready; in_ready = FIFO not full.
REQ-014 FIFO: DEPTH entries of {a,b}, circular read/write pointers with wrap at DEPTH, count width clog2(DEPTH)+1.
REQ-015 Simultaneous push and pop when full: in_ready is 0, so no push occurs; simultaneous push and pop when empty: the pushed pair is not popped the same cycle.
REQ-016 FSM states: IDLE, ISSUE, WAIT, DRAIN.
REQ-017 IDLE -> ISSUE when the FIFO is non-empty: pop the head into registered mul_a and mul_b.
REQ-018 ISSUE lasts exactly one cycle with mul_valid_in=1, then -> WAIT; mul_valid_in=0 in all other states.
REQ-019 In ISSUE, mul_valid_out is ignored, because it may still be high from the previous job.
REQ-020 WAIT: on the first cycle mul_valid_out=1, capture mul_r into out_r, set out_valid=1 and -> DRAIN.
REQ-021 The multiplier's done level may persist after completion; only the first high cycle in WAIT counts.
REQ-022 WAIT cycle counter, 5 bits, cleared on entry: if it reaches TIMEOUT without done, set err_timeout, load out_r=0, -> DRAIN.
REQ-023 DRAIN: hold out_valid and out_r until out_ready; on handshake clear out_valid, increment jobs_done (wraps 0xFFFF->0) and -> IDLE.
REQ-024 Issue-to-issue minimum spacing is 4 cycles (ISSUE, WAIT>=1, DRAIN>=1, IDLE); results leave strictly in input order.
REQ-025 FIFO pushes continue in every state.

Reset
REQ-026 rst SHALL, at the clock edge it is sampled high, set FSM=IDLE, FIFO empty, in_ready=1, mul_valid_in=0, mul_a=mul_b=0, out_valid=0, out_r=0, jobs_done=0, err_timeout=0.
REQ-027 A reset mid-job discards the FIFO contents and the in-flight job; any later mul_valid_out is ignored until a new ISSUE.
REQ-028 err_timeout is cleared only by rst.

Structure
REQ-029 A shared package mul_pkg SHALL hold the FSM state enum, the operand-pair struct {a[31:0], b[31:0]} and the width constants 32/64.
REQ-030 The FIFO SHALL be one sub-module, operand_fifo, parameterised by DEPTH; the FSM, timeout counter and output register sit in mul_scheduler.

Verification
REQ-031 Push (3,5) with a behavioural multiplier model of latency 9 -> one mul_valid_in pulse, out_r=15, jobs_done=1.
REQ-032 Push (0xFFFFFFFF,0xFFFFFFFF) -> out_r=0xFFFFFFFE00000001.
REQ-033 Push (0,7) with model done after 2 cycles, its done level held high, then push (2,2) -> outputs 0 then 4, exactly two pulses.
REQ-034 DEPTH=4: push 6 pairs back-to-back with out_ready=0 -> in_ready drops after 5 accepted (4 in FIFO, 1 issued); release out_ready -> all 6 products out in order.
REQ-035 Model never asserts done -> err_timeout=1 after 15 WAIT cycles, out_r=0, then the next job proceeds normally.
REQ-036 Assert rst during WAIT with 2 queued -> all outputs at reset values next cycle; a stale mul_valid_out produces no output.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and widths for the multiplier job scheduler.
package mul_pkg;

  localparam int DATA_W     = 32;
  localparam int PROD_W     = 64;
  localparam int WAIT_CNT_W = 5;
  localparam int JOBS_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } mul_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/mul_scheduler_if.sv
// Operand input, multiplier start/done and result handshakes of the scheduler.
interface mul_scheduler_if;
  import mul_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;

  logic              mul_valid_in;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic              mul_valid_out;
  logic [PROD_W-1:0] mul_r;

  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] out_r;

  logic [JOBS_W-1:0] jobs_done;
  logic              err_timeout;

  // master is the surrounding system; slave is the scheduler itself
  modport master (
    output in_valid, in_a, in_b,
    input  in_ready,
    input  mul_valid_in, mul_a, mul_b,
    output mul_valid_out, mul_r,
    input  out_valid, out_r,
    output out_ready,
    input  jobs_done, err_timeout
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready,
    output mul_valid_in, mul_a, mul_b,
    input  mul_valid_out, mul_r,
    output out_valid, out_r,
    input  out_ready,
    output jobs_done, err_timeout
  );

endinterface

// File: rtl/operand_fifo.sv
// Circular FIFO of operand pairs; a push into an empty FIFO is only visible
// at the head on the following cycle.
module operand_fifo
  import mul_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  operand_pair_t push_data,
  input  logic          pop,
  output operand_pair_t pop_data,
  output logic          full,
  output logic          empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  operand_pair_t    mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mul_scheduler.sv
// Feeds queued operand pairs one at a time to an iterative multiplier and
// returns the products in order through a valid/ready output.
module mul_scheduler
  import mul_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst,
  mul_scheduler_if.slave bus
);

  mul_state_e        state_q, state_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d;
  logic [DATA_W-1:0] mul_b_q, mul_b_d;
  logic [PROD_W-1:0] out_r_q, out_r_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic [JOBS_W-1:0] jobs_q, jobs_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  operand_pair_t push_pair;
  operand_pair_t head_pair;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;

  assign push_pair = '{a: bus.in_a, b: bus.in_b};

  operand_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.in_valid),
    .push_data (push_pair),
    .pop       (fifo_pop),
    .pop_data  (head_pair),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.in_ready     = !fifo_full;
  assign bus.mul_valid_in = (state_q == ISSUE);
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_r        = out_r_q;
  assign bus.jobs_done    = jobs_q;
  assign bus.err_timeout  = err_q;

  always_comb begin
    state_d     = state_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    out_r_d     = out_r_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    jobs_d      = jobs_q;
    wait_cnt_d  = wait_cnt_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          mul_a_d  = head_pair.a;
          mul_b_d  = head_pair.b;
          state_d  = ISSUE;
        end
      end
      // done is not looked at here: it may still be high from the last job
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (bus.mul_valid_out) begin
          out_r_d     = bus.mul_r;
          out_valid_d = 1'b1;
          state_d     = DRAIN;
        end else if (wait_cnt_q == WAIT_CNT_W'(TIMEOUT - 1)) begin
          err_d       = 1'b1;
          out_r_d     = '0;
          out_valid_d = 1'b1;
          state_d     = DRAIN;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          jobs_d      = jobs_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      jobs_q      <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      jobs_q      <= jobs_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_mul_scheduler.sv
// Directed bench for mul_scheduler with a behavioural iterative multiplier
// whose done level stays high until the next start pulse.
module tb_mul_scheduler;
  import mul_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mul_scheduler_if bus ();

  mul_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int pulses    = 0;
  int model_lat = 9;

  // Multiplier model: latency 0 means it never finishes
  logic        mv_out = 1'b0;
  logic [63:0] mv_r   = '0;
  logic [63:0] m_a    = '0;
  logic [63:0] m_b    = '0;
  int          m_cnt  = 0;

  assign bus.mul_valid_out = mv_out;
  assign bus.mul_r         = mv_r;

  always @(posedge clk) begin
    if (bus.mul_valid_in) begin
      m_a    <= {32'd0, bus.mul_a};
      m_b    <= {32'd0, bus.mul_b};
      m_cnt  <= model_lat;
      mv_out <= 1'b0;
    end else if (m_cnt == 1) begin
      mv_out <= 1'b1;
      mv_r   <= m_a * m_b;
      m_cnt  <= 0;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (bus.mul_valid_in) pulses++;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_output("push_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [63:0] exp);
    int n = 0;
    while (!bus.out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check_output({tag, "_r"}, bus.out_r, exp);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_output({tag, "_cleared"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    check_output({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check_output({tag, "_mul_valid_in"}, 64'(bus.mul_valid_in), 64'd0);
    check_output({tag, "_mul_a"}, 64'(bus.mul_a), 64'd0);
    check_output({tag, "_mul_b"}, 64'(bus.mul_b), 64'd0);
    check_output({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check_output({tag, "_out_r"}, bus.out_r, 64'd0);
    check_output({tag, "_jobs_done"}, 64'(bus.jobs_done), 64'd0);
    check_output({tag, "_err"}, 64'(bus.err_timeout), 64'd0);
  endtask

  logic [31:0] qa [6];
  logic [31:0] qb [6];
  logic [63:0] qr [6];

  initial begin
    int p0;
    int acc;
    int n;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    qa[0] = 32'd1;       qb[0] = 32'd1;       qr[0] = 64'd1;
    qa[1] = 32'd2;       qb[1] = 32'd3;       qr[1] = 64'd6;
    qa[2] = 32'd10;      qb[2] = 32'd10;      qr[2] = 64'd100;
    qa[3] = 32'h10000;   qb[3] = 32'h10000;   qr[3] = 64'h1_0000_0000;
    qa[4] = 32'd7;       qb[4] = 32'd6;       qr[4] = 64'd42;
    qa[5] = 32'hFFFF;    qb[5] = 32'd2;       qr[5] = 64'h1FFFE;

    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single job, latency 9
    model_lat = 9;
    p0 = pulses;
    apply_stimulus(32'd3, 32'd5);
    n = 0;
    while (!bus.mul_valid_in && n < 16) begin
      @(negedge clk);
      n++;
    end
    check_output("issue_a", 64'(bus.mul_a), 64'd3);
    check_output("issue_b", 64'(bus.mul_b), 64'd5);
    expect_result("job_3x5", 64'd15);
    check_output("hold_a", 64'(bus.mul_a), 64'd3);
    check_output("pulses_3x5", 64'(pulses - p0), 64'd1);
    check_output("jobs_1", 64'(bus.jobs_done), 64'd1);

    // Largest operands
    apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_result("job_max", 64'hFFFF_FFFE_0000_0001);
    check_output("jobs_2", 64'(bus.jobs_done), 64'd2);

    // Done level stays high between jobs and must not leak into the next one
    model_lat = 2;
    p0 = pulses;
    apply_stimulus(32'd0, 32'd7);
    expect_result("job_0x7", 64'd0);
    check_output("done_held", 64'(bus.mul_valid_out), 64'd1);
    apply_stimulus(32'd2, 32'd2);
    expect_result("job_2x2", 64'd4);
    check_output("pulses_two", 64'(pulses - p0), 64'd2);
    check_output("jobs_4", 64'(bus.jobs_done), 64'd4);

    // Back-to-back pushes while the output is stalled
    model_lat = 3;
    acc = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_a = qa[i];
      bus.in_b = qb[i];
      if (!bus.in_ready) break;
      acc++;
      @(negedge clk);
    end
    if (acc == 6) bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_output("full_ready", 64'(bus.in_ready), 64'd0);
    check_output("accepted", 64'(acc), 64'd5);
    expect_result("q0", qr[0]);
    n = 0;
    while (!bus.in_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    check_output("ready_again", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    expect_result("q1", qr[1]);
    expect_result("q2", qr[2]);
    expect_result("q3", qr[3]);
    expect_result("q4", qr[4]);
    expect_result("q5", qr[5]);
    check_output("jobs_10", 64'(bus.jobs_done), 64'd10);

    // Multiplier never completes
    model_lat = 0;
    apply_stimulus(32'd4, 32'd4);
    n = 0;
    while (!bus.mul_valid_in && n < 16) begin
      @(negedge clk);
      n++;
    end
    check_output("to_issue", 64'(bus.mul_valid_in), 64'd1);
    @(negedge clk);
    check_output("issue_one_cycle", 64'(bus.mul_valid_in), 64'd0);
    repeat (14) @(negedge clk);
    check_output("to_err_early", 64'(bus.err_timeout), 64'd0);
    check_output("to_valid_early", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check_output("to_err", 64'(bus.err_timeout), 64'd1);
    expect_result("timeout", 64'd0);
    model_lat = 5;
    apply_stimulus(32'd6, 32'd7);
    expect_result("after_to", 64'd42);
    check_output("err_sticky", 64'(bus.err_timeout), 64'd1);
    check_output("jobs_12", 64'(bus.jobs_done), 64'd12);

    // Reset while waiting with two pairs still queued
    model_lat = 6;
    bus.in_valid = 1'b1;
    bus.in_a = 32'd1; bus.in_b = 32'd2;
    @(negedge clk);
    bus.in_a = 32'd3; bus.in_b = 32'd4;
    @(negedge clk);
    bus.in_a = 32'd5; bus.in_b = 32'd6;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_output("pre_rst_a", 64'(bus.mul_a), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midjob");
    rst = 1'b0;
    p0 = pulses;
    repeat (12) @(negedge clk);
    check_output("stale_done", 64'(bus.mul_valid_out), 64'd1);
    check_output("stale_no_out", 64'(bus.out_valid), 64'd0);
    check_output("stale_no_issue", 64'(pulses - p0), 64'd0);
    check_output("stale_jobs", 64'(bus.jobs_done), 64'd0);
    apply_stimulus(32'd9, 32'd9);
    expect_result("post_rst", 64'd81);
    check_output("jobs_after_rst", 64'(bus.jobs_done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
